track_scheduler: RTL

Sequences the shared external RAM between one recording stream and NUM_TRACKS playback streams, one audio sample at a time. It sits between the waveform/mixer path and the asynchronous RAM controller. On every sample tick it issues at most one write (the live signal into the armed track) and then one read per playing track, through a single request/acknowledge port. It also owns the per-track address pointers and recorded lengths, and produces the saturated mix of all track samples read back.

---
 rtl/track_pkg.sv | 21 ++
 rtl/edge_detect.sv | 24 ++
 rtl/track_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/track_pkg.sv
// Shared types and helpers for the track scheduler: FSM states, default
// geometry, and 16-bit saturation for the mix output.
package track_pkg;

  localparam int NUM_TRACKS_DEF = 2;
  localparam int TRACK_AW_DEF   = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_MIX
  } state_e;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)       return 16'sh7fff;
    else if (v < -32'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising/falling edge detector. While en_i is low the previous value is
// held, so an edge seen during that time is reported once en_i returns.
module edge_detect #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] sig_i,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prev_q <= '0;
    else if (en_i) prev_q <= sig_i;
  end

  assign rise_o = en_i ? (sig_i & ~prev_q) : '0;
  assign fall_o = en_i ? (~sig_i & prev_q) : '0;

endmodule

// File: rtl/track_scheduler.sv
// Per-sample RAM sequencer: one record write, then one read per playing
// track, over a single req/ack port; accumulates and saturates the mix.
module track_scheduler
  import track_pkg::*;
#(
  parameter int NUM_TRACKS = NUM_TRACKS_DEF,
  parameter int TRACK_AW   = TRACK_AW_DEF,
  parameter int ADDR_W     = 23,
  localparam int TW        = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  rec_en,
  input  logic [TW-1:0]         rec_track,
  input  logic [15:0]           rec_data,
  input  logic [NUM_TRACKS-1:0] play_mask,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic [15:0]           mix_out,
  output logic                  mix_valid,
  output logic                  rec_full,
  output logic                  overrun
);

  localparam int ACC_W = 16 + $clog2(NUM_TRACKS + 1);
  localparam logic [TRACK_AW:0]   FULL_LEN = {1'b1, {TRACK_AW{1'b0}}};
  localparam logic [TRACK_AW:0]   ONE_L    = 1;
  localparam logic [TRACK_AW-1:0] ONE_P    = 1;

  state_e                                 state_q;
  logic                                   req_q, we_q, mix_vld_q;
  logic [ADDR_W-1:0]                      addr_q;
  logic [15:0]                            wdata_q;
  logic signed [15:0]                     mix_q;
  logic                                   rec_full_q, overrun_q, rec_act_q;
  logic [TW-1:0]                          rec_trk_q, cur_q;
  logic [TRACK_AW-1:0]                    wr_ptr_q;
  logic [NUM_TRACKS-1:0][TRACK_AW:0]      len_q;
  logic [NUM_TRACKS-1:0][TRACK_AW-1:0]    rd_ptr_q;
  logic [NUM_TRACKS-1:0]                  snap_q;
  logic signed [ACC_W-1:0]                acc_q;

  logic                                   idle;
  logic                                   rec_rise, rec_fall;
  logic [NUM_TRACKS-1:0]                  play_rise, play_fall;

  // Control values as they stand after any edge seen this idle cycle
  logic                                   rec_act_e, rec_full_e;
  logic [TW-1:0]                          rec_trk_e;
  logic [TRACK_AW-1:0]                    wr_ptr_e;
  logic [NUM_TRACKS-1:0][TRACK_AW:0]      len_e;
  logic [NUM_TRACKS-1:0][TRACK_AW-1:0]    rd_ptr_e;

  logic                                   first_ok, wr_nxt_ok, rd_nxt_ok, rd_wrap;
  logic [TW-1:0]                          first_t, wr_nxt_t, rd_nxt_t;
  logic signed [ACC_W-1:0]                rd_ext, sum;
  logic signed [31:0]                     sum_w, acc_w;

  assign idle = (state_q == ST_IDLE);

  edge_detect #(.W(1)) u_rec_edge (
    .clk(clk), .rst(rst), .en_i(idle), .sig_i(rec_en),
    .rise_o(rec_rise), .fall_o(rec_fall)
  );

  edge_detect #(.W(NUM_TRACKS)) u_play_edge (
    .clk(clk), .rst(rst), .en_i(idle), .sig_i(play_mask),
    .rise_o(play_rise), .fall_o(play_fall)
  );

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TW-1:0] t,
                                                input logic [TRACK_AW-1:0] p);
    return ADDR_W'({t, p});
  endfunction

  // Lowest track index >= from that is playing, non-empty and not recording
  function automatic logic [TW:0] find_rd(input logic [NUM_TRACKS-1:0] mask,
                                          input logic [NUM_TRACKS-1:0][TRACK_AW:0] len,
                                          input logic act,
                                          input logic [TW-1:0] trk,
                                          input int from);
    logic [TW:0] r;
    r = '0;
    for (int t = NUM_TRACKS - 1; t >= 0; t--)
      if (t >= from && mask[t] && len[t] != '0 && !(act && trk == TW'(t)))
        r = {1'b1, TW'(t)};
    return r;
  endfunction

  always_comb begin
    rec_act_e  = rec_act_q;
    rec_full_e = rec_full_q;
    rec_trk_e  = rec_trk_q;
    wr_ptr_e   = wr_ptr_q;
    len_e      = len_q;
    rd_ptr_e   = rd_ptr_q;
    if (rec_fall) begin
      if (rec_act_q) len_e[rec_trk_q] = {1'b0, wr_ptr_q};
      rec_act_e = 1'b0;
    end
    if (rec_rise) begin
      rec_act_e  = 1'b1;
      rec_full_e = 1'b0;
      rec_trk_e  = rec_track;
      wr_ptr_e   = '0;
    end
    // A stopped track is never read, so rewinding it on the falling edge
    // too is indistinguishable from rewinding it on restart.
    for (int t = 0; t < NUM_TRACKS; t++)
      if (play_rise[t] || play_fall[t]) rd_ptr_e[t] = '0;
  end

  assign {first_ok, first_t}   = find_rd(play_mask, len_e, rec_act_e, rec_trk_e, 0);
  assign {wr_nxt_ok, wr_nxt_t} = find_rd(snap_q, len_q, rec_act_q, rec_trk_q, 0);
  assign {rd_nxt_ok, rd_nxt_t} = find_rd(snap_q, len_q, rec_act_q, rec_trk_q, int'(cur_q) + 1);

  assign rd_wrap = ({1'b0, rd_ptr_q[cur_q]} + ONE_L) == len_q[cur_q];
  assign rd_ext  = {{(ACC_W-16){mem_rdata[15]}}, mem_rdata};
  assign sum     = acc_q + rd_ext;
  assign sum_w   = 32'(sum);
  assign acc_w   = 32'(acc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mix_q      <= '0;
      mix_vld_q  <= 1'b0;
      rec_full_q <= 1'b0;
      overrun_q  <= 1'b0;
      rec_act_q  <= 1'b0;
      rec_trk_q  <= '0;
      cur_q      <= '0;
      wr_ptr_q   <= '0;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      snap_q     <= '0;
      acc_q      <= '0;
    end else begin
      mix_vld_q <= 1'b0;
      if (sample_tick && !idle) overrun_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          rec_act_q  <= rec_act_e;
          rec_full_q <= rec_full_e;
          rec_trk_q  <= rec_trk_e;
          wr_ptr_q   <= wr_ptr_e;
          len_q      <= len_e;
          rd_ptr_q   <= rd_ptr_e;
          if (sample_tick) begin
            snap_q  <= play_mask;
            wdata_q <= rec_data;
            if (rec_act_e) begin
              state_q <= ST_WRITE;
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= mk_addr(rec_trk_e, wr_ptr_e);
            end else if (first_ok) begin
              state_q <= ST_READ;
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              cur_q   <= first_t;
              addr_q  <= mk_addr(first_t, rd_ptr_e[first_t]);
            end else begin
              state_q <= ST_MIX;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wr_ptr_q <= wr_ptr_q + ONE_P;
            if (&wr_ptr_q) begin
              len_q[rec_trk_q] <= FULL_LEN;
              rec_full_q       <= 1'b1;
              rec_act_q        <= 1'b0;
            end
            // Leaving req low here gives the mandatory gap before the first read
            if (wr_nxt_ok) begin
              state_q <= ST_READ;
              cur_q   <= wr_nxt_t;
            end else begin
              mix_q     <= sat16(acc_w);
              mix_vld_q <= 1'b1;
              acc_q     <= '0;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_READ: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            addr_q <= mk_addr(cur_q, rd_ptr_q[cur_q]);
          end else if (mem_ack) begin
            req_q           <= 1'b0;
            rd_ptr_q[cur_q] <= rd_wrap ? '0 : rd_ptr_q[cur_q] + ONE_P;
            if (rd_nxt_ok) begin
              cur_q <= rd_nxt_t;
              acc_q <= sum;
            end else begin
              mix_q     <= sat16(sum_w);
              mix_vld_q <= 1'b1;
              acc_q     <= '0;
              state_q   <= ST_IDLE;
            end
          end
        end
        ST_MIX: begin
          mix_q     <= sat16(acc_w);
          mix_vld_q <= 1'b1;
          acc_q     <= '0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mix_out   = mix_q;
  assign mix_valid = mix_vld_q;
  assign rec_full  = rec_full_q;
  assign overrun   = overrun_q;

endmodule
